// File: rtl/game_pkg.sv
// Shared game definitions: object identities, scheduler states and the slot-word layout
// exchanged with the object-update logic.
package game_pkg;

  localparam int unsigned NUM_SLOTS_MAX = 8;
  localparam int unsigned SLOT_IDX_W    = $clog2(NUM_SLOTS_MAX);

  localparam logic [1:0] OBJ_COLLECT = 2'd0;
  localparam logic [1:0] OBJ_HAZARD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_PICK       = 2'd2,
    ST_ISSUE      = 2'd3
  } spawn_state_e;

  localparam int unsigned SW_FRAME_MSB = 25;
  localparam int unsigned SW_FRAME_LSB = 23;
  localparam int unsigned SW_ID_MSB    = 22;
  localparam int unsigned SW_ID_LSB    = 21;
  localparam int unsigned SW_HPOS_MSB  = 20;
  localparam int unsigned SW_HPOS_LSB  = 10;
  localparam int unsigned SW_VPOS_MSB  = 9;
  localparam int unsigned SW_VPOS_LSB  = 0;

  // Packed so that the fields land exactly on the bit positions above.
  typedef struct packed {
    logic [2:0]  frame;
    logic [1:0]  id;
    logic [10:0] hpos;
    logic [9:0]  vpos;
  } slot_word_t;

endpackage

// File: rtl/rr_slot_picker.sv
// Combinational round-robin search: first free slot scanning from ptr_i upward, modulo N.
module rr_slot_picker
  import game_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0]            free_i,
  input  logic [SLOT_IDX_W-1:0]   ptr_i,
  output logic                    found_c,
  output logic [SLOT_IDX_W-1:0]   index_c
);

  logic [SLOT_IDX_W:0] cand;

  always_comb begin
    found_c = 1'b0;
    index_c = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (SLOT_IDX_W+1)'(ptr_i) + (SLOT_IDX_W+1)'(k);
      if (cand >= (SLOT_IDX_W+1)'(N)) cand = cand - (SLOT_IDX_W+1)'(N);
      if (!found_c && free_i[cand[SLOT_IDX_W-1:0]]) begin
        found_c = 1'b1;
        index_c = cand[SLOT_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/obj_spawn_scheduler.sv
// Per-frame object spawn decision, round-robin slot pick and valid/ready command issue.
// Define SPAWN_RAMP_EN to raise the hazard threshold with score.
module obj_spawn_scheduler
  import game_pkg::*;
#(
  parameter int unsigned NUM_SLOTS     = 5,
  parameter int unsigned RATE_BITS     = 7,
  parameter int unsigned MIN_GAP       = 8,
  parameter int unsigned HAZARD_THRESH = 64,
  parameter int unsigned VPOS_BASE     = 220,
  parameter int unsigned SCREEN_WIDTH  = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_pulse,
  input  logic [31:0]           random,
  input  logic [NUM_SLOTS-1:0]  slot_busy,
  input  logic [7:0]            score,
  output logic                  spawn_valid,
  input  logic                  spawn_ready,
  output logic [2:0]            spawn_slot,
  output logic [1:0]            spawn_id,
  output logic [10:0]           spawn_hpos,
  output logic [9:0]            spawn_vpos,
  output logic                  cooldown_active
);

  localparam int unsigned CW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  spawn_state_e    state_q, state_d;
  logic            valid_q, valid_d;
  logic [2:0]      slot_q, slot_d;
  logic [1:0]      id_q, id_d;
  logic [10:0]     hpos_q, hpos_d;
  logic [9:0]      vpos_q, vpos_d;
  logic [2:0]      rr_q, rr_d;
  logic [CW-1:0]   cool_q, cool_d;
  logic [15:0]     rnd_q, rnd_d;
  logic            cdact_q, cdact_d;

  logic            rate_hit_c;
  logic            pick_found_c;
  logic [2:0]      pick_idx_c;
  logic [7:0]      thresh_c;
  logic [NUM_SLOTS-1:0] free_mask_c;
  logic            unused_inputs;

  assign rate_hit_c    = (random[31 -: RATE_BITS] == '0);
  assign free_mask_c   = ~slot_busy;
  // Only the rate field and the low 16 bits of random are consumed.
  assign unused_inputs = ^{random, score};

`ifdef SPAWN_RAMP_EN
  logic [8:0] ramp_sum_c;
  assign ramp_sum_c = 9'(HAZARD_THRESH) + 9'(score[7:2]);
  assign thresh_c   = ramp_sum_c[8] ? 8'hFF : ramp_sum_c[7:0];
`else
  assign thresh_c   = 8'(HAZARD_THRESH);
`endif

  rr_slot_picker #(.N(NUM_SLOTS)) u_picker (
    .free_i  (free_mask_c),
    .ptr_i   (rr_q),
    .found_c (pick_found_c),
    .index_c (pick_idx_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      slot_q  <= '0;
      id_q    <= '0;
      hpos_q  <= '0;
      vpos_q  <= '0;
      rr_q    <= '0;
      cool_q  <= '0;
      rnd_q   <= '0;
      cdact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      slot_q  <= slot_d;
      id_q    <= id_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      rr_q    <= rr_d;
      cool_q  <= cool_d;
      rnd_q   <= rnd_d;
      cdact_q <= cdact_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    slot_d  = slot_q;
    id_d    = id_q;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    rr_d    = rr_q;
    cool_d  = cool_q;
    rnd_d   = rnd_q;

    if (!enable) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      cool_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_FRAME;
        ST_WAIT_FRAME: begin
          if (frame_pulse) begin
            if (cool_q != '0) begin
              cool_d = cool_q - CW'(1);
            end else if (rate_hit_c && !(&slot_busy)) begin
              rnd_d   = random[15:0];
              state_d = ST_PICK;
            end
          end
        end
        // Slot occupancy is re-evaluated here; a late fill aborts the decision.
        ST_PICK: begin
          if (pick_found_c) begin
            slot_d  = pick_idx_c;
            id_d    = (rnd_q[15:8] < thresh_c) ? OBJ_HAZARD : OBJ_COLLECT;
            hpos_d  = 11'(SCREEN_WIDTH);
            vpos_d  = 10'(VPOS_BASE) + 10'(rnd_q[7:0]);
            valid_d = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_WAIT_FRAME;
          end
        end
        ST_ISSUE: begin
          if (spawn_ready) begin
            valid_d = 1'b0;
            rr_d    = (slot_q == 3'(NUM_SLOTS - 1)) ? 3'd0 : slot_q + 3'd1;
            cool_d  = CW'(MIN_GAP);
            state_d = ST_WAIT_FRAME;
          end else if (slot_busy[slot_q]) begin
            valid_d = 1'b0;
            state_d = ST_WAIT_FRAME;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    cdact_d = (cool_d != '0);
  end

  assign spawn_valid     = valid_q;
  assign spawn_slot      = slot_q;
  assign spawn_id        = id_q;
  assign spawn_hpos      = hpos_q;
  assign spawn_vpos      = vpos_q;
  assign cooldown_active = cdact_q;

endmodule

// File: tb/tb_obj_spawn_scheduler.sv
// Self-checking bench for obj_spawn_scheduler: directed scenarios plus randomized frames
// against a frame-level reference model (slot choice, cooldown, hazard class).
module tb_obj_spawn_scheduler;

  localparam int NS      = 5;
  localparam int MIN_GAP = 8;
  localparam int HAZ     = 64;
  localparam int VBASE   = 220;
  localparam int SW      = 1024;
`ifdef SPAWN_RAMP_EN
  localparam int RAMP    = 1;
`else
  localparam int RAMP    = 0;
`endif

  logic        clock = 1'b0;
  logic        reset, enable, frame_pulse, spawn_ready;
  logic [31:0] random;
  logic [4:0]  slot_busy;
  logic [7:0]  score;
  logic        spawn_valid, cooldown_active;
  logic [2:0]  spawn_slot;
  logic [1:0]  spawn_id;
  logic [10:0] spawn_hpos;
  logic [9:0]  spawn_vpos;

  int checks = 0;
  int errors = 0;
  int m_rr   = 0;
  int m_cool = 0;

  always #5 clock = ~clock;

  obj_spawn_scheduler #(
    .NUM_SLOTS(NS), .RATE_BITS(7), .MIN_GAP(MIN_GAP),
    .HAZARD_THRESH(HAZ), .VPOS_BASE(VBASE), .SCREEN_WIDTH(SW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .frame_pulse(frame_pulse),
    .random(random), .slot_busy(slot_busy), .score(score),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_slot(spawn_slot),
    .spawn_id(spawn_id), .spawn_hpos(spawn_hpos), .spawn_vpos(spawn_vpos),
    .cooldown_active(cooldown_active)
  );

  // Reference: first free slot at or after the round-robin pointer, wrapping.
  function automatic int model_pick(input logic [4:0] busy);
    for (int k = 0; k < NS; k++)
      if (!busy[(m_rr + k) % NS]) return (m_rr + k) % NS;
    return -1;
  endfunction

  function automatic logic [1:0] model_id(input logic [31:0] r, input logic [7:0] sc);
    int thr;
    thr = HAZ + RAMP * (int'(sc) / 4);
    if (thr > 255) thr = 255;
    return (int'(r[15:8]) < thr) ? 2'd1 : 2'd0;
  endfunction

  task automatic model_frame(input logic [31:0] r, input logic [4:0] busy, output logic exp);
    exp = 1'b0;
    if (m_cool != 0) m_cool = m_cool - 1;
    else exp = (r[31:25] == 7'd0) && (busy != 5'h1f);
  endtask

  task automatic pulse_frame(input logic [31:0] r, input logic [4:0] busy,
                             output logic v1, output logic v2);
    @(negedge clock);
    random = r; slot_busy = busy; frame_pulse = 1'b1;
    @(negedge clock);
    frame_pulse = 1'b0; v1 = spawn_valid;
    @(negedge clock);
    v2 = spawn_valid;
  endtask

  // Holds ready low for 'stall' cycles (pulsing frame_pulse, which must be ignored), then accepts.
  task automatic accept(input int stall, output logic stable, output logic v_after, output logic cd_after);
    logic [25:0] p;
    p = {spawn_slot, spawn_id, spawn_hpos, spawn_vpos};
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      if (!spawn_valid || {spawn_slot, spawn_id, spawn_hpos, spawn_vpos} !== p) stable = 1'b0;
      frame_pulse = 1'b1; random = '0;
    end
    @(negedge clock);
    if (!spawn_valid || {spawn_slot, spawn_id, spawn_hpos, spawn_vpos} !== p) stable = 1'b0;
    frame_pulse = 1'b0; spawn_ready = 1'b1;
    @(negedge clock);
    spawn_ready = 1'b0; v_after = spawn_valid; cd_after = cooldown_active;
    m_rr = (int'(p[25:23]) + 1) % NS;
    m_cool = MIN_GAP;
  endtask

  task automatic burn_cooldown();
    logic v1, v2, e;
    while (m_cool != 0) begin
      model_frame(32'h0, 5'h0, e);
      pulse_frame(32'h0, 5'h0, v1, v2);
      checks++;
      if (v1 !== 1'b0 || v2 !== e) begin
        errors++; $display("FAIL burn_cooldown valid got %b want %b", v2, e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; frame_pulse = 1'b0; spawn_ready = 1'b0;
    random = '0; slot_busy = '0; score = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({spawn_valid, spawn_slot, spawn_id, spawn_hpos, spawn_vpos, cooldown_active} !== '0) begin
      errors++; $display("FAIL reset_outputs got v=%b s=%0d id=%0d h=%0d vp=%0d cd=%b want all 0",
        spawn_valid, spawn_slot, spawn_id, spawn_hpos, spawn_vpos, cooldown_active);
    end
    m_rr = 0; m_cool = 0;
    enable = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic_spawn();
    logic v1, v2, st, va, cd;
    pulse_frame(32'h0000_1234, 5'b00000, v1, v2);
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b1) begin
      errors++; $display("FAIL basic_latency got v1=%b v2=%b want 0 1", v1, v2);
    end
    checks++;
    if (spawn_slot !== 3'd0 || spawn_id !== 2'd1 || spawn_vpos !== 10'd272 || spawn_hpos !== 11'd1024) begin
      errors++; $display("FAIL basic_payload got s=%0d id=%0d vp=%0d h=%0d want 0 1 272 1024",
        spawn_slot, spawn_id, spawn_vpos, spawn_hpos);
    end
    accept(2, st, va, cd);
    checks++;
    if (st !== 1'b1 || va !== 1'b0 || cd !== 1'b1) begin
      errors++; $display("FAIL basic_accept got stable=%b valid=%b cd=%b want 1 0 1", st, va, cd);
    end
  endtask

  task automatic test_cooldown();
    logic v1, v2, e, any_v, cd_low;
    any_v = 1'b0; cd_low = 1'b0;
    for (int i = 0; i < MIN_GAP; i++) begin
      if (cooldown_active !== 1'b1) cd_low = 1'b1;
      model_frame(32'h0, 5'h0, e);
      pulse_frame(32'h0, 5'h0, v1, v2);
      if (v1 || v2) any_v = 1'b1;
    end
    checks++;
    if (any_v !== 1'b0 || cd_low !== 1'b0) begin
      errors++; $display("FAIL cooldown_window got spawn=%b cd_dropped=%b want 0 0", any_v, cd_low);
    end
    checks++;
    if (cooldown_active !== 1'b0) begin
      errors++; $display("FAIL cooldown_end got %b want 0", cooldown_active);
    end
  endtask

  task automatic test_round_robin();
    logic v1, v2, st, va, cd, e;
    int es;
    es = model_pick(5'b00011);
    model_frame(32'h0, 5'b00011, e);
    pulse_frame(32'h0, 5'b00011, v1, v2);
    checks++;
    if (v2 !== 1'b1 || spawn_slot !== 3'd2 || int'(spawn_slot) != es) begin
      errors++; $display("FAIL rr_slot got v=%b s=%0d want 1 2", v2, spawn_slot);
    end
    accept(0, st, va, cd);
    burn_cooldown();
    for (int i = 0; i < 4; i++) begin
      model_frame(32'h0, 5'h1f, e);
      pulse_frame(32'h0, 5'h1f, v1, v2);
      checks++;
      if (v1 !== 1'b0 || v2 !== 1'b0) begin
        errors++; $display("FAIL all_busy frame %0d got v=%b want 0", i, v2);
      end
    end
  endtask

  task automatic test_withdraw();
    logic v1, v2, st, va, cd, e;
    int es;
    logic [4:0] busy;
    es = model_pick(5'h0);
    model_frame(32'h0000_8080, 5'h0, e);
    pulse_frame(32'h0000_8080, 5'h0, v1, v2);
    checks++;
    if (v2 !== 1'b1 || int'(spawn_slot) != es) begin
      errors++; $display("FAIL withdraw_spawn got v=%b s=%0d want 1 %0d", v2, spawn_slot, es);
    end
    @(negedge clock);
    busy = slot_busy; busy[spawn_slot] = 1'b1; slot_busy = busy;
    @(negedge clock);
    checks++;
    if (spawn_valid !== 1'b0 || cooldown_active !== 1'b0) begin
      errors++; $display("FAIL withdraw_drop got v=%b cd=%b want 0 0", spawn_valid, cooldown_active);
    end
    es = model_pick(busy);
    model_frame(32'h0000_0000, busy, e);
    pulse_frame(32'h0000_0000, busy, v1, v2);
    checks++;
    if (v2 !== 1'b1 || int'(spawn_slot) != es) begin
      errors++; $display("FAIL withdraw_repick got v=%b s=%0d want 1 %0d", v2, spawn_slot, es);
    end
    accept(1, st, va, cd);
    burn_cooldown();
  endtask

  task automatic test_rate_gate();
    logic v1, v2, e, any_v;
    logic [31:0] r;
    any_v = 1'b0;
    for (int i = 0; i < 100; i++) begin
      r = $urandom; r[31:25] = 7'h01;
      model_frame(r, 5'h0, e);
      pulse_frame(r, 5'h0, v1, v2);
      if (v1 || v2) any_v = 1'b1;
    end
    checks++;
    if (any_v !== 1'b0) begin
      errors++; $display("FAIL rate_gate got spawn=%b want 0", any_v);
    end
  endtask

  task automatic test_enable_drop();
    logic v1, v2, e;
    int es;
    burn_cooldown();
    es = model_pick(5'h0);
    model_frame(32'h0, 5'h0, e);
    pulse_frame(32'h0, 5'h0, v1, v2);
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    checks++;
    if (v2 !== 1'b1 || spawn_valid !== 1'b0 || cooldown_active !== 1'b0) begin
      errors++; $display("FAIL enable_drop got pre=%b post=%b cd=%b want 1 0 0", v2, spawn_valid, cooldown_active);
    end
    m_cool = 0;
    enable = 1'b1;
    @(negedge clock);
    model_frame(32'h0, 5'h0, e);
    pulse_frame(32'h0, 5'h0, v1, v2);
    checks++;
    if (v2 !== 1'b1 || int'(spawn_slot) != es) begin
      errors++; $display("FAIL enable_rr_kept got v=%b s=%0d want 1 %0d", v2, spawn_slot, es);
    end
  endtask

  task automatic test_reset_mid_issue();
    logic v1, v2, st, va, cd, e;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (spawn_valid !== 1'b0 || cooldown_active !== 1'b0 || spawn_slot !== 3'd0 || spawn_hpos !== 11'd0) begin
      errors++; $display("FAIL reset_mid_issue got v=%b cd=%b s=%0d h=%0d want 0 0 0 0",
        spawn_valid, cooldown_active, spawn_slot, spawn_hpos);
    end
    m_rr = 0; m_cool = 0;
    @(negedge clock);
    model_frame(32'h0, 5'h0, e);
    pulse_frame(32'h0, 5'h0, v1, v2);
    checks++;
    if (v2 !== 1'b1 || spawn_slot !== 3'd0) begin
      errors++; $display("FAIL reset_rr got v=%b s=%0d want 1 0", v2, spawn_slot);
    end
    accept(0, st, va, cd);
  endtask

  task automatic test_ramp();
    logic v1, v2, st, va, cd, e;
    logic [1:0] want;
    burn_cooldown();
    score = 8'd200;
    want = (RAMP != 0) ? 2'd1 : 2'd0;
    model_frame({16'h0000, 8'd110, 8'h10}, 5'h0, e);
    pulse_frame({16'h0000, 8'd110, 8'h10}, 5'h0, v1, v2);
    checks++;
    if (v2 !== 1'b1 || spawn_id !== want || spawn_id !== model_id({16'h0000, 8'd110, 8'h10}, 8'd200)) begin
      errors++; $display("FAIL ramp_id got v=%b id=%0d want 1 %0d", v2, spawn_id, want);
    end
    accept(0, st, va, cd);
    score = 8'd0;
  endtask

  task automatic test_random();
    logic v1, v2, st, va, cd, e;
    logic [31:0] r;
    logic [4:0] busy;
    int es;
    for (int it = 0; it < 200; it++) begin
      score = 8'($urandom);
      r = $urandom;
      if ($urandom_range(0, 2) != 0) r[31:25] = 7'd0;
      busy = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) busy = 5'h1f;
      es = model_pick(busy);
      model_frame(r, busy, e);
      pulse_frame(r, busy, v1, v2);
      checks++;
      if (v1 !== 1'b0 || v2 !== e) begin
        errors++; $display("FAIL rnd_valid it %0d got %b%b want 0%b", it, v1, v2, e);
      end
      if (e && v2) begin
        checks++;
        if (int'(spawn_slot) != es || spawn_id !== model_id(r, score) ||
            int'(spawn_vpos) != (VBASE + int'(r[7:0])) % 1024 || int'(spawn_hpos) != SW) begin
          errors++; $display("FAIL rnd_payload it %0d got s=%0d id=%0d vp=%0d h=%0d want %0d %0d %0d %0d",
            it, spawn_slot, spawn_id, spawn_vpos, spawn_hpos, es, model_id(r, score),
            (VBASE + int'(r[7:0])) % 1024, SW);
        end
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clock);
          busy[spawn_slot] = 1'b1; slot_busy = busy;
          @(negedge clock);
          checks++;
          if (spawn_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_withdraw it %0d got %b want 0", it, spawn_valid);
          end
        end else begin
          accept(int'($urandom_range(0, 3)), st, va, cd);
          checks++;
          if (st !== 1'b1 || va !== 1'b0) begin
            errors++; $display("FAIL rnd_accept it %0d got stable=%b valid=%b want 1 0", it, st, va);
          end
        end
      end
      checks++;
      if (cooldown_active !== (m_cool != 0)) begin
        errors++; $display("FAIL rnd_cooldown it %0d got %b want %b", it, cooldown_active, m_cool != 0);
      end
    end
    score = 8'd0;
  endtask

  initial begin
    test_reset();
    test_basic_spawn();
    test_cooldown();
    test_round_robin();
    test_withdraw();
    test_rate_gate();
    test_enable_drop();
    test_reset_mid_issue();
    test_ramp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
